regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipelined core.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: set at issue, cleared at writeback, bulk-cleared on flush. Decode uses it for hazard stalls.

---
 rtl/pipeline_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 90 +++++++++
 tb/tb_regfile_mp.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default core widths and register-index types.
package pipeline_pkg;
    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int REGIDX_WIDTH = $clog2(NUM_REGS_DEF);

    typedef logic [REGIDX_WIDTH-1:0] regidx_t;
    typedef logic [XLEN_DEF-1:0]     xlen_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, bulk-cleared on flush.
module regfile_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int IDXW    = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_en,
    input  logic [IDXW-1:0]                issue_rd,
    input  logic                           flush,
    input  logic [NUM_REGS-1:0]            wr_clr,
    input  logic [NUM_RD-1:0][IDXW-1:0]    query_addr,
    output logic [NUM_RD-1:0]              query_busy
);
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    // Flush kills the issuing instruction; a new producer supersedes a pending writeback.
    always_comb begin
        busy_next = busy_reg;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush) begin
                busy_next[r] = 1'b0;
            end else if (issue_en && (issue_rd == IDXW'(r))) begin
                busy_next[r] = 1'b1;
            end else if (wr_clr[r]) begin
                busy_next[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_query
        assign query_busy[gi] = busy_reg[query_addr[gi]];
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
    import pipeline_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int IDXW    = (NUM_REGS == NUM_REGS_DEF) ? REGIDX_WIDTH : $clog2(NUM_REGS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_RD-1:0][IDXW-1:0]    i_rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]    o_rd_data,
    output logic [NUM_RD-1:0]              o_rd_busy,
    input  logic [NUM_WR-1:0]              i_wr_en,
    input  logic [NUM_WR-1:0][IDXW-1:0]    i_wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]    i_wr_data,
    input  logic                           i_issue_en,
    input  logic [IDXW-1:0]                i_issue_rd,
    input  logic                           i_flush
);
    logic [XLEN-1:0]     regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [XLEN-1:0]     wr_val   [NUM_REGS];
    logic [NUM_RD-1:0]   sb_busy;
    logic                issue_ok;

    // Ascending port order makes the highest-index enabled port win a collision.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_val[r] = '0;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k] && !((ZERO_REG != 0) && (i_wr_addr[k] == '0))) begin
                wr_hit[i_wr_addr[k]] = 1'b1;
                wr_val[i_wr_addr[k]] = i_wr_data[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs_reg[r] <= wr_val[r];
                end
            end
        end
    end

    assign issue_ok = i_issue_en && !((ZERO_REG != 0) && (i_issue_rd == '0));

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .issue_en   (issue_ok),
        .issue_rd   (i_issue_rd),
        .flush      (i_flush),
        .wr_clr     (wr_hit),
        .query_addr (i_rd_addr),
        .query_busy (sb_busy)
    );

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [IDXW-1:0] addr;
        logic            bypass_hit;
        logic            zero_hit;

        assign addr       = i_rd_addr[gi];
        assign bypass_hit = (BYPASS != 0) && wr_hit[addr];
        assign zero_hit   = (ZERO_REG != 0) && (addr == '0);

        assign o_rd_data[gi] = zero_hit   ? '0 :
                               bypass_hit ? wr_val[addr] : regs_reg[addr];
        // Bypassed data is already valid, so the pending producer no longer stalls the reader.
        assign o_rd_busy[gi] = sb_busy[gi] & ~bypass_hit;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a bypassing and a non-bypassing register file share stimulus and a reference model.
module tb_regfile_mp;
    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data_b, rd_data_n;
    logic [1:0]       rd_busy_b, rd_busy_n;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             issue_en;
    logic [4:0]       issue_rd;
    logic             flush;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_issue_en(issue_en), .i_issue_rd(issue_rd), .i_flush(flush)
    );

    regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)) dut_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_issue_en(issue_en), .i_issue_rd(issue_rd), .i_flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        issue_en = 1'b0;
        issue_rd = '0;
        flush    = 1'b0;
        rd_addr  = '0;
    endtask

    // Architectural view of one clock edge: writes land, writeback frees, issue claims, flush wipes.
    task automatic cycle();
        logic [31:0] nregs [32];
        bit          nbusy [32];
        nregs = m_regs;
        nbusy = m_busy;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                nregs[r] = 0;
                nbusy[r] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k] && wr_addr[k] != 0) begin
                    nregs[wr_addr[k]] = wr_data[k];
                    nbusy[wr_addr[k]] = 0;
                end
            end
            if (issue_en && issue_rd != 0) nbusy[issue_rd] = 1;
            if (flush) begin
                for (int r = 0; r < 32; r++) nbusy[r] = 0;
            end
        end
        @(posedge clk);
        #1;
        m_regs = nregs;
        m_busy = nbusy;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp) begin
            for (int k = 1; k >= 0; k--) begin
                if (wr_en[k] && wr_addr[k] == a) return wr_data[k];
            end
        end
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((wr_en[0] && wr_addr[0] == a) || (wr_en[1] && wr_addr[1] == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        cycle();
        cycle();
        rst_n = 1'b1;
        #2;
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a);
            #1;
            checks++; if (rd_data_b[0] !== 32'h0) begin errors++; $display("FAIL reset_data_b x%0d got=%h exp=0", a, rd_data_b[0]); end
            checks++; if (rd_data_n[0] !== 32'h0) begin errors++; $display("FAIL reset_data_n x%0d got=%h exp=0", a, rd_data_n[0]); end
            checks++; if (rd_busy_b[0] !== 1'b0) begin errors++; $display("FAIL reset_busy_b x%0d got=%b exp=0", a, rd_busy_b[0]); end
            checks++; if (rd_busy_n[0] !== 1'b0) begin errors++; $display("FAIL reset_busy_n x%0d got=%b exp=0", a, rd_busy_n[0]); end
        end
        wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd0;
        #2;
        checks++; if (rd_data_b[0] !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rd_data_b[0]); end
        cycle();
        idle();
        #2;
        checks++; if (rd_data_b[0] !== 32'h0) begin errors++; $display("FAIL x0_after_b got=%h exp=0", rd_data_b[0]); end
        checks++; if (rd_data_n[0] !== 32'h0) begin errors++; $display("FAIL x0_after_n got=%h exp=0", rd_data_n[0]); end
        $display("test_reset done");
    endtask

    task automatic test_basic_rw();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'h12345678;
        cycle();
        idle();
        rd_addr[1] = 5'd5; rd_addr[0] = 5'd6;
        #2;
        checks++; if (rd_data_n[1] !== 32'h12345678) begin errors++; $display("FAIL basic_x5 got=%h exp=12345678", rd_data_n[1]); end
        checks++; if (rd_data_b[1] !== 32'h12345678) begin errors++; $display("FAIL basic_x5_b got=%h exp=12345678", rd_data_b[1]); end
        checks++; if (rd_data_n[0] !== 32'h0) begin errors++; $display("FAIL basic_x6 got=%h exp=0", rd_data_n[0]); end
        $display("test_basic_rw done");
    endtask

    task automatic test_bypass();
        idle();
        issue_en = 1'b1; issue_rd = 5'd7;
        cycle();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'hA5A5A5A5; rd_addr[0] = 5'd7;
        #2;
        checks++; if (rd_data_b[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_data got=%h exp=a5a5a5a5", rd_data_b[0]); end
        checks++; if (rd_busy_b[0] !== 1'b0) begin errors++; $display("FAIL bypass_busy got=%b exp=0", rd_busy_b[0]); end
        checks++; if (rd_data_n[0] !== 32'h0) begin errors++; $display("FAIL nobypass_data got=%h exp=0", rd_data_n[0]); end
        checks++; if (rd_busy_n[0] !== 1'b1) begin errors++; $display("FAIL nobypass_busy got=%b exp=1", rd_busy_n[0]); end
        cycle();
        idle();
        rd_addr[0] = 5'd7;
        #2;
        checks++; if (rd_data_n[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_after got=%h exp=a5a5a5a5", rd_data_n[0]); end
        checks++; if (rd_busy_n[0] !== 1'b0) begin errors++; $display("FAIL bypass_after_busy got=%b exp=0", rd_busy_n[0]); end
        $display("test_bypass done");
    endtask

    task automatic test_collision();
        idle();
        wr_en = 2'b11;
        wr_addr[0] = 5'd3; wr_data[0] = 32'h1;
        wr_addr[1] = 5'd3; wr_data[1] = 32'h2;
        rd_addr[1] = 5'd3;
        #2;
        checks++; if (rd_data_b[1] !== 32'h2) begin errors++; $display("FAIL collide_bypass got=%h exp=2", rd_data_b[1]); end
        cycle();
        idle();
        rd_addr[1] = 5'd3;
        #2;
        checks++; if (rd_data_n[1] !== 32'h2) begin errors++; $display("FAIL collide_stored_n got=%h exp=2", rd_data_n[1]); end
        checks++; if (rd_data_b[1] !== 32'h2) begin errors++; $display("FAIL collide_stored_b got=%h exp=2", rd_data_b[1]); end
        $display("test_collision done");
    endtask

    task automatic test_scoreboard();
        idle();
        issue_en = 1'b1; issue_rd = 5'd9;
        cycle();
        idle();
        rd_addr[0] = 5'd9;
        #2;
        checks++; if (rd_busy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_issue_n got=%b exp=1", rd_busy_n[0]); end
        checks++; if (rd_busy_b[0] !== 1'b1) begin errors++; $display("FAIL sb_issue_b got=%b exp=1", rd_busy_b[0]); end
        wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h00000909;
        cycle();
        idle();
        rd_addr[0] = 5'd9;
        #2;
        checks++; if (rd_busy_n[0] !== 1'b0) begin errors++; $display("FAIL sb_wb_clear got=%b exp=0", rd_busy_n[0]); end
        checks++; if (rd_data_n[0] !== 32'h00000909) begin errors++; $display("FAIL sb_wb_data got=%h exp=00000909", rd_data_n[0]); end
        issue_en = 1'b1; issue_rd = 5'd9;
        wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h00009999;
        cycle();
        idle();
        rd_addr[0] = 5'd9;
        #2;
        checks++; if (rd_busy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_issue_beats_wb got=%b exp=1", rd_busy_n[0]); end
        checks++; if (rd_busy_b[0] !== 1'b1) begin errors++; $display("FAIL sb_issue_beats_wb_b got=%b exp=1", rd_busy_b[0]); end
        checks++; if (rd_data_n[0] !== 32'h00009999) begin errors++; $display("FAIL sb_issue_wb_data got=%h exp=00009999", rd_data_n[0]); end
        $display("test_scoreboard done");
    endtask

    task automatic test_flush_reset();
        idle();
        issue_en = 1'b1; issue_rd = 5'd4;
        cycle();
        issue_rd = 5'd10;
        cycle();
        idle();
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd10;
        #2;
        checks++; if (rd_busy_n !== 2'b11) begin errors++; $display("FAIL flush_pre got=%b exp=11", rd_busy_n); end
        flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd11;
        cycle();
        idle();
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd10;
        #2;
        checks++; if (rd_busy_n !== 2'b00) begin errors++; $display("FAIL flush_clear got=%b exp=00", rd_busy_n); end
        rd_addr[0] = 5'd11;
        #1;
        checks++; if (rd_busy_n[0] !== 1'b0) begin errors++; $display("FAIL flush_kills_issue got=%b exp=0", rd_busy_n[0]); end
        rst_n = 1'b0;
        wr_en[0] = 1'b1; wr_addr[0] = 5'd2; wr_data[0] = 32'hFF;
        issue_en = 1'b1; issue_rd = 5'd12;
        cycle();
        rst_n = 1'b1;
        idle();
        rd_addr[0] = 5'd2; rd_addr[1] = 5'd5;
        #2;
        checks++; if (rd_data_n[0] !== 32'h0) begin errors++; $display("FAIL rst_drops_write got=%h exp=0", rd_data_n[0]); end
        checks++; if (rd_data_n[1] !== 32'h0) begin errors++; $display("FAIL rst_clears_x5 got=%h exp=0", rd_data_n[1]); end
        rd_addr[0] = 5'd12;
        #1;
        checks++; if (rd_busy_n[0] !== 1'b0) begin errors++; $display("FAIL rst_drops_issue got=%b exp=0", rd_busy_n[0]); end
        $display("test_flush_reset done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            idle();
            rst_n = ($urandom_range(0, 39) != 0);
            for (int k = 0; k < 2; k++) begin
                wr_en[k]   = $urandom_range(0, 1) != 0;
                wr_addr[k] = 5'($urandom_range(0, 7));
                wr_data[k] = $urandom;
                rd_addr[k] = 5'($urandom_range(0, 7));
            end
            issue_en = $urandom_range(0, 1) != 0;
            issue_rd = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            #2;
            for (int j = 0; j < 2; j++) begin
                checks++; if (rd_data_b[j] !== exp_data(rd_addr[j], 1)) begin errors++; $display("FAIL rnd%0d data_b p%0d got=%h exp=%h", i, j, rd_data_b[j], exp_data(rd_addr[j], 1)); end
                checks++; if (rd_data_n[j] !== exp_data(rd_addr[j], 0)) begin errors++; $display("FAIL rnd%0d data_n p%0d got=%h exp=%h", i, j, rd_data_n[j], exp_data(rd_addr[j], 0)); end
                checks++; if (rd_busy_b[j] !== exp_busy(rd_addr[j], 1)) begin errors++; $display("FAIL rnd%0d busy_b p%0d got=%b exp=%b", i, j, rd_busy_b[j], exp_busy(rd_addr[j], 1)); end
                checks++; if (rd_busy_n[j] !== exp_busy(rd_addr[j], 0)) begin errors++; $display("FAIL rnd%0d busy_n p%0d got=%b exp=%b", i, j, rd_busy_n[j], exp_busy(rd_addr[j], 0)); end
            end
            $display("txn %0d rst_n=%b wr=%b a0=%0d a1=%0d iss=%b/%0d fl=%b rd=%0d,%0d", i, rst_n, wr_en,
                     wr_addr[0], wr_addr[1], issue_en, issue_rd, flush, rd_addr[0], rd_addr[1]);
            cycle();
        end
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 0;
            m_busy[r] = 0;
        end
        test_reset();
        test_basic_rw();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_flush_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
